// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the mult/div sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    EXC    = 3'd4,
    TOUT   = 3'd5
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Selector values expected by mux_High / mux_Low
  localparam logic HILO_SEL_MULT = 1'b0;
  localparam logic HILO_SEL_DIV  = 1'b1;

  function automatic logic op_to_hilo(input logic op);
    return (op == OP_DIV) ? HILO_SEL_DIV : HILO_SEL_MULT;
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-state watchdog: clearable up-counter with a terminal-count flag.
module muldiv_watchdog #(
  parameter int unsigned LIMIT = 63
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Count is 0 in the first WAIT cycle, so LIMIT-1 marks the LIMIT-th cycle
  assign tc = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches mult/div, waits for completion, drives HI/LO loads and status.
// Optional watchdog abort enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op_div,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  input  logic mf_req,
  output logic mult_init,
  output logic div_init,
  output logic hilo_sel,
  output logic high_load,
  output logic low_load,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_err,
  output logic mf_stall
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   stop_hit, zero_hit, tout_hit;

  // Only the latched unit's signals are observed
  assign stop_hit = (op_q == OP_DIV) ? div_stop : mult_stop;
  assign zero_hit = (op_q == OP_DIV) && div_zero;

`ifdef MULDIV_TIMEOUT_EN
  muldiv_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk   (clk),
    .rst_n (reset),
    .clr   (state_q == LAUNCH),
    .en    ((state_q == WAIT) && !stop_hit && !zero_hit),
    .tc    (tout_hit)
  );
`else
  assign tout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      IDLE: if (start) begin
        op_d    = op_div;
        state_d = LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (zero_hit)      state_d = EXC;
        else if (stop_hit) state_d = WRITE;
        else if (tout_hit) state_d = TOUT;
      end
      WRITE, EXC, TOUT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    mult_init    = (state_q == LAUNCH) && (op_q == OP_MULT);
    div_init     = (state_q == LAUNCH) && (op_q == OP_DIV);
    hilo_sel     = op_to_hilo(op_q);
    high_load    = (state_q == WRITE);
    low_load     = (state_q == WRITE);
    busy         = (state_q != IDLE);
    done         = (state_q == WRITE) || (state_q == EXC) || (state_q == TOUT);
    div_zero_exc = (state_q == EXC);
`ifdef MULDIV_TIMEOUT_EN
    timeout_err  = (state_q == TOUT);
`else
    timeout_err  = 1'b0;
`endif
  end

  assign mf_stall = mf_req & busy;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed plan plus randomized transactions.
module tb_muldiv_sequencer;

  localparam int TO = 8;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic reset, start, op_div, mult_stop, div_stop, div_zero, mf_req;
  logic mult_init, div_init, hilo_sel, high_load, low_load, busy, done;
  logic div_zero_exc, timeout_err, mf_stall;

  int errors = 0;
  int checks = 0;
  logic prev_op;

  // Per-cycle stimulus tables for one transaction, cycle 0 = start cycle
  logic st[N], od[N], ms[N], ds[N], dz[N], mf[N];

  always #5 clk = ~clk;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div),
    .mult_stop(mult_stop), .div_stop(div_stop), .div_zero(div_zero),
    .mf_req(mf_req), .mult_init(mult_init), .div_init(div_init),
    .hilo_sel(hilo_sel), .high_load(high_load), .low_load(low_load),
    .busy(busy), .done(done), .div_zero_exc(div_zero_exc),
    .timeout_err(timeout_err), .mf_stall(mf_stall)
  );

  function automatic logic [9:0] obs_vec();
    return {mult_init, div_init, hilo_sel, high_load, low_load,
            busy, done, div_zero_exc, timeout_err, mf_stall};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = obs_vec();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      st[i] = 1'b0; od[i] = 1'b0; ms[i] = 1'b0;
      ds[i] = 1'b0; dz[i] = 1'b0; mf[i] = 1'b0;
    end
  endtask

  task automatic drive(input int c);
    start = st[c]; op_div = od[c]; mult_stop = ms[c];
    div_stop = ds[c]; div_zero = dz[c]; mf_req = mf[c];
  endtask

  // Reference: find the first WAIT-cycle exit (cycle >= 2) for the selected
  // unit, then the transaction ends one cycle later with the matching outcome.
  task automatic exec(input logic op, input string name);
    int k, e, kind; // kind: 0 write, 1 div-zero, 2 timeout
    logic [9:0] exp;
    logic bz, fin;
    st[0] = 1'b1;
    od[0] = op;
    k = -1;
    for (int c = 2; c < N - 2; c++)
      if (k < 0 && (op ? (ds[c] | dz[c]) : ms[c])) k = c;
`ifdef MULDIV_TIMEOUT_EN
    if (k < 0 || k > TO + 1) begin
      e = TO + 2; kind = 2;
    end else begin
      e = k + 1; kind = (op && dz[k]) ? 1 : 0;
    end
`else
    if (k < 0) begin
      errors++;
      $display("FAIL %s model: no completion in table", name);
      k = N - 3;
    end
    e = k + 1; kind = (op && dz[k]) ? 1 : 0;
`endif
    for (int c = 0; c <= e; c++) begin
      drive(c);
      @(negedge clk);
      bz  = (c >= 1);
      fin = (c == e);
      exp = {(c == 1) && !op, (c == 1) && op, (c == 0) ? prev_op : op,
             fin && kind == 0, fin && kind == 0, bz, fin,
             fin && kind == 1, fin && kind == 2, mf[c] & bz};
      chk($sformatf("%s c%0d", name, c), exp);
      @(posedge clk); #1;
    end
    prev_op = op;
  endtask

  task automatic idle(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      start = 1'b0; op_div = 1'b0; mult_stop = 1'b0;
      div_stop = 1'b0; div_zero = 1'b0; mf_req = 1'b1;
      @(negedge clk);
      chk($sformatf("%s i%0d", name, c), {2'b00, prev_op, 7'b0});
      @(posedge clk); #1;
    end
  endtask

  task automatic rand_txn(input int t);
    logic op;
    int k;
    op = 1'($urandom);
    k  = 2 + int'($urandom_range(0, 14));
    clear_stim();
    for (int c = 0; c <= k + 1; c++) begin
      if (c > 0) st[c] = ($urandom_range(0, 3) == 0);
      if (c > 0) od[c] = 1'($urandom);
      mf[c] = 1'($urandom);
      if (op) begin
        ms[c] = 1'($urandom);
        if (c < 2 || c > k) begin
          dz[c] = 1'($urandom); ds[c] = 1'($urandom);
        end else if (c == k) begin
          dz[c] = 1'($urandom); ds[c] = dz[c] ? 1'($urandom) : 1'b1;
        end
      end else begin
        ds[c] = 1'($urandom); dz[c] = 1'($urandom);
        if (c < 2 || c > k) ms[c] = 1'($urandom);
        else if (c == k)    ms[c] = 1'b1;
      end
    end
    exec(op, $sformatf("rnd%0d", t));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_div = 1'b0; mult_stop = 1'b0;
    div_stop = 1'b0; div_zero = 1'b0; mf_req = 1'b1;
    prev_op = 1'b0;
    #12;
    chk("reset", 10'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2, "post_reset");

    clear_stim(); ms[34] = 1'b1;
    exec(1'b0, "mult34");

    clear_stim(); dz[5] = 1'b1; ds[5] = 1'b1;
    exec(1'b1, "divzero");

    clear_stim(); ms[4] = 1'b1; ds[10] = 1'b1;
    exec(1'b1, "wrong_unit");

    clear_stim(); st[3] = 1'b1; mf[3] = 1'b1; ms[6] = 1'b1;
    exec(1'b0, "start_busy");
    idle(1, "mf_after_done");

    for (int t = 0; t < 40; t++) rand_txn(t);

    // Reset during LAUNCH of a DIV, then a stale div_stop
    start = 1'b1; op_div = 1'b1; mult_stop = 1'b0; div_stop = 1'b0;
    div_zero = 1'b0; mf_req = 1'b0;
    @(negedge clk);
    chk("rst_mid c0", {2'b00, prev_op, 7'b0});
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_mid launch", 10'b0110010000);
    #2 reset = 1'b0;
    #1 chk("rst_mid asserted", 10'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    prev_op = 1'b0;
    div_stop = 1'b1;
    @(negedge clk);
    chk("rst_mid stale_stop", 10'b0);
    @(posedge clk); #1;
    idle(3, "rst_mid after");

`ifdef MULDIV_TIMEOUT_EN
    clear_stim();
    exec(1'b1, "watchdog");
    idle(2, "watchdog after");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
